// File: rtl/mem_loader_cu.sv
// mem_loader_cu: control unit that streams filter coefficients and image words
// from a single-port memory into the filter and image buffers, one outstanding
// read at a time, with stall, abort and image-only reload support.
module mem_loader_cu #(
    parameter int NUM_FILTERS  = 4,
    parameter int FILTER_WORDS = 4,
    parameter int IMG_WORDS    = 64,
    parameter int ADDR_W       = 8,
    parameter int FILTER_BASE  = 0,
    parameter int IMG_BASE     = 16,
    localparam int FS_W = (NUM_FILTERS  > 1) ? $clog2(NUM_FILTERS)  : 1,
    localparam int FW_W = (FILTER_WORDS > 1) ? $clog2(FILTER_WORDS) : 1,
    localparam int IW_W = (IMG_WORDS    > 1) ? $clog2(IMG_WORDS)    : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              skip_filters,
    input  logic              abort,
    input  logic              mem_rd_valid,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              filter_wr_en,
    output logic [FS_W-1:0]   filter_sel,
    output logic [FW_W-1:0]   filter_word_idx,
    output logic              img_wr_en,
    output logic [IW_W-1:0]   img_word_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        INIT        = 3'd1,
        LD_FILTER   = 3'd2,
        NEXT_FILTER = 3'd3,
        LD_IMG      = 3'd4,
        DONE        = 3'd5
    } state_t;

    localparam logic [FS_W-1:0] SEL_LAST  = FS_W'(NUM_FILTERS - 1);
    localparam logic [FW_W-1:0] FWORD_LAST = FW_W'(FILTER_WORDS - 1);
    localparam logic [IW_W-1:0] IWORD_LAST = IW_W'(IMG_WORDS - 1);

    state_t             state;
    logic               skip_q;
    logic [ADDR_W-1:0]  filt_addr;
    logic [ADDR_W-1:0]  img_addr;

    // Addresses wrap modulo 2^ADDR_W by doing all arithmetic at ADDR_W bits.
    assign filt_addr = ADDR_W'(FILTER_BASE)
                     + ADDR_W'(filter_sel) * ADDR_W'(FILTER_WORDS)
                     + ADDR_W'(filter_word_idx);
    assign img_addr  = ADDR_W'(IMG_BASE) + ADDR_W'(img_word_idx);

    // Output decode from the state register; buffer writes follow the memory
    // handshake in the same cycle, and abort suppresses a coincident write.
    always_comb begin
        mem_rd_req   = (state == LD_FILTER) || (state == LD_IMG);
        mem_addr     = (state == LD_IMG) ? img_addr : filt_addr;
        filter_wr_en = (state == LD_FILTER) && mem_rd_valid && !abort;
        img_wr_en    = (state == LD_IMG) && mem_rd_valid && !abort;
        busy         = (state != IDLE);
    end

    // Sequencer: state, counters, latched mode and the registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            skip_q          <= 1'b0;
            filter_sel      <= '0;
            filter_word_idx <= '0;
            img_word_idx    <= '0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state           <= IDLE;
                filter_sel      <= '0;
                filter_word_idx <= '0;
                img_word_idx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= INIT;
                            skip_q <= skip_filters;
                        end
                    end
                    INIT: begin
                        filter_sel      <= '0;
                        filter_word_idx <= '0;
                        img_word_idx    <= '0;
                        state           <= skip_q ? LD_IMG : LD_FILTER;
                    end
                    LD_FILTER: begin
                        if (mem_rd_valid) begin
                            if (filter_word_idx == FWORD_LAST) begin
                                filter_word_idx <= '0;
                                state           <= NEXT_FILTER;
                            end else begin
                                filter_word_idx <= filter_word_idx + 1'b1;
                            end
                        end
                    end
                    NEXT_FILTER: begin
                        if (filter_sel == SEL_LAST) begin
                            state <= LD_IMG;
                        end else begin
                            filter_sel <= filter_sel + 1'b1;
                            state      <= LD_FILTER;
                        end
                    end
                    LD_IMG: begin
                        // The last index is held so counters keep final values.
                        if (mem_rd_valid) begin
                            if (img_word_idx == IWORD_LAST) begin
                                state <= DONE;
                            end else begin
                                img_word_idx <= img_word_idx + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader_cu.sv
// Scoreboard bench for mem_loader_cu: a reference model lists the buffer
// writes and done pulse each run must produce; a monitor pops and compares.
module tb_mem_loader_cu;

    localparam int NF = 4, FW = 4, IW = 64, AW = 8, FB = 0, IB = 16;
    localparam int LAT_FULL = 2 + NF * (FW + 1) + IW;
    localparam int LAT_SKIP = 2 + IW;
    localparam int ALL = 1 << 30;

    logic clk = 1'b0;
    logic rst_n, start, skip_filters, abort, mem_rd_valid;
    logic mem_rd_req, filter_wr_en, img_wr_en, busy, done;
    logic [AW-1:0] mem_addr;
    logic [1:0] filter_sel, filter_word_idx;
    logic [5:0] img_word_idx;

    logic s_start, s_skip, s_abort, s_valid;
    logic s_req, s_fwe, s_iwe, s_busy, s_done;
    logic [AW-1:0] s_addr;
    logic s_fsel, s_fidx, s_iidx;

    mem_loader_cu #(.NUM_FILTERS(NF), .FILTER_WORDS(FW), .IMG_WORDS(IW),
                    .ADDR_W(AW), .FILTER_BASE(FB), .IMG_BASE(IB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_filters(skip_filters),
        .abort(abort), .mem_rd_valid(mem_rd_valid), .mem_rd_req(mem_rd_req),
        .mem_addr(mem_addr), .filter_wr_en(filter_wr_en), .filter_sel(filter_sel),
        .filter_word_idx(filter_word_idx), .img_wr_en(img_wr_en),
        .img_word_idx(img_word_idx), .busy(busy), .done(done)
    );

    mem_loader_cu #(.NUM_FILTERS(1), .FILTER_WORDS(1), .IMG_WORDS(1),
                    .ADDR_W(AW), .FILTER_BASE(3), .IMG_BASE(200)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .skip_filters(s_skip),
        .abort(s_abort), .mem_rd_valid(s_valid), .mem_rd_req(s_req),
        .mem_addr(s_addr), .filter_wr_en(s_fwe), .filter_sel(s_fsel),
        .filter_word_idx(s_fidx), .img_wr_en(s_iwe),
        .img_word_idx(s_iidx), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 filter write, 1 image write, 2 done
        int addr;
        int a;
        int b;
        int cyc;    // expected done cycle, -1 = not checked
    } ev_t;

    ev_t sbq[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a run is the ordered list of buffer writes plus done;
    // an aborted or reset run keeps only its first 'keep' events and no done.
    task automatic push_run(input bit skip, input int keep, input int done_cyc);
        ev_t e;
        int n = 0;
        if (!skip) begin
            for (int f = 0; f < NF; f++) begin
                for (int w = 0; w < FW; w++) begin
                    e.kind = 0; e.addr = (FB + f * FW + w) % 256;
                    e.a = f; e.b = w; e.cyc = -1;
                    if (n < keep) sbq.push_back(e);
                    n++;
                end
            end
        end
        for (int i = 0; i < IW; i++) begin
            e.kind = 1; e.addr = (IB + i) % 256; e.a = i; e.b = 0; e.cyc = -1;
            if (n < keep) sbq.push_back(e);
            n++;
        end
        e.kind = 2; e.addr = 0; e.a = 0; e.b = 0; e.cyc = done_cyc;
        if (n < keep) sbq.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int addr, input int a,
                            input int b, input int flag);
        ev_t e;
        bit ok;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected kind=%0d addr=%0d a=%0d b=%0d cycle=%0d expected no event",
                     kind, addr, a, b, cyc);
        end else begin
            e = sbq.pop_front();
            if (kind == 2)
                ok = (e.kind == 2) && (e.cyc < 0 || e.cyc == cyc) && (flag == 1);
            else
                ok = (e.kind == kind) && (e.addr == addr) && (e.a == a) &&
                     (e.b == b) && (flag == 1);
            if (!ok) begin
                bad++;
                $display("FAIL sb_event kind=%0d addr=%0d a=%0d b=%0d cycle=%0d flag=%0d expected kind=%0d addr=%0d a=%0d b=%0d cycle=%0d flag=1",
                         kind, addr, a, b, cyc, flag, e.kind, e.addr, e.a, e.b, e.cyc);
            end
        end
    endtask

    // Monitor: every write strobe and done pulse is matched against the model.
    always @(negedge clk) begin
        #2;
        if (filter_wr_en)
            check_ev(0, int'(mem_addr), int'(filter_sel), int'(filter_word_idx), int'(mem_rd_req));
        if (img_wr_en)
            check_ev(1, int'(mem_addr), int'(img_word_idx), 0, int'(mem_rd_req));
        if (done)
            check_ev(2, 0, 0, 0, int'(!busy));
    end

    task automatic launch(input bit skip, input int keep, input int lat);
        @(negedge clk);
        push_run(skip, keep, (lat < 0) ? -1 : cyc + 1 + lat);
        skip_filters = skip;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        skip_filters = 1'($urandom_range(0, 1));
    endtask

    task automatic run_until_idle(input bit rnd_valid, input bit start_noise, input int limit);
        int k = 0;
        while ((sbq.size() != 0 || busy) && k < limit) begin
            @(negedge clk);
            if (rnd_valid) mem_rd_valid = ($urandom_range(0, 9) < 7);
            start = start_noise && busy && ($urandom_range(0, 7) == 0);
            k++;
        end
        start = 1'b0;
        mem_rd_valid = 1'b1;
        total++;
        if (k >= limit) begin
            bad++;
            $display("FAIL run_timeout waited=%0d cycles, expected idle within %0d", k, limit);
        end
    endtask

    task automatic wait_filter_pos(input int f, input int w, input int limit);
        int k = 0;
        while (!(mem_rd_req && int'(filter_sel) == f && int'(filter_word_idx) == w) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("wait_filter_pos_timeout", int'(k >= limit), 0);
    endtask

    int t0, nf, ni, nd, fa, ia, dc;

    initial begin
        rst_n = 1'b0; start = 1'b0; skip_filters = 1'b0; abort = 1'b0; mem_rd_valid = 1'b1;
        s_start = 1'b0; s_skip = 1'b0; s_abort = 1'b0; s_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", int'(mem_rd_req), 0);
        check("rst_addr", int'(mem_addr), FB);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", int'(filter_sel) + int'(filter_word_idx) + int'(img_word_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full run, valid always high, stray starts while busy must be ignored.
        launch(1'b0, ALL, LAT_FULL);
        run_until_idle(1'b0, 1'b1, 400);

        // Image-only reload.
        launch(1'b1, ALL, LAT_SKIP);
        run_until_idle(1'b0, 1'b1, 400);

        // Three-cycle stall at filter 2 word 1.
        launch(1'b0, ALL, LAT_FULL + 3);
        wait_filter_pos(2, 1, 200);
        mem_rd_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #2;
            check("stall_addr", int'(mem_addr), 9);
            check("stall_nowrite", int'(filter_wr_en), 0);
            @(negedge clk);
        end
        mem_rd_valid = 1'b1;
        run_until_idle(1'b0, 1'b0, 400);

        // Abort together with valid at image word 10.
        launch(1'b0, NF * FW + 10, -1);
        begin
            int k = 0;
            while (!(mem_rd_req && int'(img_word_idx) == 10) && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("wait_img10_timeout", int'(k >= 200), 0);
        end
        abort = 1'b1;
        #2;
        check("abort_no_imgwr", int'(img_wr_en), 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_req", int'(mem_rd_req), 0);
        repeat (4) @(negedge clk);
        check("abort_sb_empty", sbq.size(), 0);
        launch(1'b0, ALL, LAT_FULL);
        run_until_idle(1'b0, 1'b0, 400);

        // start and abort together in IDLE: no run.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);

        // Reset mid filter load.
        launch(1'b0, FW + 2, -1);
        wait_filter_pos(1, 2, 200);
        rst_n = 1'b0;
        #1;
        check("midrst_req", int'(mem_rd_req), 0);
        check("midrst_addr", int'(mem_addr), FB);
        check("midrst_wr", int'(filter_wr_en) + int'(img_wr_en), 0);
        check("midrst_idx", int'(filter_sel) + int'(filter_word_idx) + int'(img_word_idx), 0);
        check("midrst_busy_done", int'(busy) + int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_sb_empty", sbq.size(), 0);

        // Randomized runs with random stalls and stray starts.
        for (int r = 0; r < 12; r++) begin
            launch(($urandom_range(0, 3) == 0), ALL, -1);
            run_until_idle(1'b1, 1'b1, 3000);
        end

        // Minimal configuration: one filter word, one image word.
        @(negedge clk);
        s_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        s_start = 1'b0;
        nf = 0; ni = 0; nd = 0; fa = -1; ia = -1; dc = -1;
        repeat (8) begin
            #2;
            if (s_fwe) begin nf++; fa = int'(s_addr); end
            if (s_iwe) begin ni++; ia = int'(s_addr); end
            if (s_done) begin nd++; dc = cyc; end
            @(negedge clk);
        end
        check("small_filter_writes", nf, 1);
        check("small_filter_addr", fa, 3);
        check("small_img_writes", ni, 1);
        check("small_img_addr", ia, 200);
        check("small_done_count", nd, 1);
        check("small_done_cycle", dc, t0 + 5);

        check("sb_final_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached time limit, expected completion");
        $fatal(1, "global time limit");
    end

endmodule
